// File: rtl/zorro_bus_master_pkg.sv
// Shared types and default timing for the Zorro II bus-cycle initiator.
// Timing constants are in z_sample_clk cycles (10 ns at 100 MHz).
package zorro_bus_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ASSERT,
    ST_STROBE,
    ST_DOE
  } state_e;

  localparam int unsigned ADDR_W = 24;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned BE_W   = 2;
  localparam int unsigned CNT_W  = 9;

  localparam int unsigned SETUP_CYC_DEF   = 13;
  localparam int unsigned AS2DS_CYC_DEF   = 14;
  localparam int unsigned STROBE_MIN_DEF  = 20;
  localparam int unsigned DOE_CYC_DEF     = 8;
  localparam int unsigned TIMEOUT_CYC_DEF = 256;

  // The counter runs down to zero, so an N-clock phase loads N-1.
  function automatic logic [CNT_W-1:0] cnt_load(input int unsigned cycles);
    return CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/zorro_bus_master_sync2.sv
// Two-flop synchronizer for the asynchronous, active-low znDTACK input.
// Both stages reset to 1 so that a reset never looks like an acknowledge.
module zorro_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/zorro_bus_master.sv
// Zorro II bus master: turns one local request into a 68k-style AS/UDS/LDS cycle.
// state | meaning: IDLE accept | SETUP addr valid, AS high | ASSERT AS low | STROBE DS low | DOE DS high, AS low
module zorro_bus_master
  import zorro_bus_master_pkg::*;
#(
  parameter int unsigned SETUP_CYC   = SETUP_CYC_DEF,
  parameter int unsigned AS2DS_CYC   = AS2DS_CYC_DEF,
  parameter int unsigned STROBE_MIN  = STROBE_MIN_DEF,
  parameter int unsigned DOE_CYC     = DOE_CYC_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter bit          WAIT_DTACK  = 1'b1
) (
  input  logic              z_sample_clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [BE_W-1:0]   req_be,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_timeout,
  output logic              znAS,
  output logic              znUDS,
  output logic              znLDS,
  output logic              zREAD,
  output logic [ADDR_W-1:0] zA,
  output logic [DATA_W-1:0] zD_out,
  output logic              zD_oe,
  input  logic [DATA_W-1:0] zD_in,
  output logic              zDOE,
  input  logic              znDTACK
);

  // Counter value at or below which STROBE_MIN clocks have elapsed in STROBE.
  localparam logic [CNT_W-1:0] MIN_LEFT = CNT_W'(TIMEOUT_CYC - STROBE_MIN);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BE_W-1:0]     be_q, be_d;
  logic [ADDR_W-1:0]   za_q, za_d;
  logic [DATA_W-1:0]   zd_out_q, zd_out_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                zread_q, zread_d;
  logic                nas_q, nas_d;
  logic                nuds_q, nuds_d;
  logic                nlds_q, nlds_d;
  logic                zd_oe_q, zd_oe_d;
  logic                zdoe_q, zdoe_d;
  logic                req_ready_q, req_ready_d;
  logic                rsp_valid_d, rsp_valid_q;
  logic                rsp_timeout_d, rsp_timeout_q;
  logic                to_flag_q, to_flag_d;
  logic                ack_seen_q, ack_seen_d;
  logic                dtack_n_sync;
  logic                ack_now;
  logic                strobe_done;
  logic                unused_addr0;

  assign unused_addr0 = req_addr[0];

  zorro_sync2 u_sync_dtack (
    .clk   (z_sample_clk),
    .rst_n (reset_n),
    .d     (znDTACK),
    .q     (dtack_n_sync)
  );

  // An acknowledge seen before STROBE_MIN has elapsed is remembered, not lost.
  assign ack_now     = ack_seen_q | ~dtack_n_sync;
  assign strobe_done = (cnt_q <= MIN_LEFT) && (ack_now || !WAIT_DTACK);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    be_d          = be_q;
    za_d          = za_q;
    zd_out_d      = zd_out_q;
    rsp_rdata_d   = rsp_rdata_q;
    zread_d       = zread_q;
    nas_d         = nas_q;
    nuds_d        = nuds_q;
    nlds_d        = nlds_q;
    zd_oe_d       = zd_oe_q;
    zdoe_d        = zdoe_q;
    req_ready_d   = req_ready_q;
    to_flag_d     = to_flag_q;
    ack_seen_d    = ack_seen_q;
    rsp_valid_d   = 1'b0;
    rsp_timeout_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid && req_ready_q) begin
          req_ready_d = 1'b0;
          if (req_be == '0) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = '0;
          end else begin
            za_d      = {req_addr[ADDR_W-1:1], 1'b0};
            zread_d   = ~req_write;
            be_d      = req_be;
            to_flag_d = 1'b0;
            if (req_write) zd_out_d = req_wdata;
            cnt_d   = cnt_load(SETUP_CYC);
            state_d = ST_SETUP;
          end
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          nas_d   = 1'b0;
          zd_oe_d = ~zread_q;
          cnt_d   = cnt_load(AS2DS_CYC);
          state_d = ST_ASSERT;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_ASSERT: begin
        if (cnt_q == '0) begin
          nuds_d     = ~be_q[1];
          nlds_d     = ~be_q[0];
          ack_seen_d = 1'b0;
          cnt_d      = cnt_load(TIMEOUT_CYC);
          state_d    = ST_STROBE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_STROBE: begin
        ack_seen_d = ack_now;
        if (strobe_done || cnt_q == '0) begin
          nuds_d    = 1'b1;
          nlds_d    = 1'b1;
          zdoe_d    = 1'b1;
          to_flag_d = ~strobe_done;
          if (strobe_done && zread_q) rsp_rdata_d = zD_in;
          cnt_d   = cnt_load(DOE_CYC);
          state_d = ST_DOE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DOE: begin
        if (cnt_q == '0) begin
          nas_d       = 1'b1;
          zd_oe_d     = 1'b0;
          zdoe_d      = 1'b0;
          req_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // The response pulse lands on the final DOE clock.
    if (state_d == ST_DOE && cnt_d == '0) begin
      rsp_valid_d   = 1'b1;
      rsp_timeout_d = to_flag_d;
    end
  end

  always_ff @(posedge z_sample_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      be_q          <= '0;
      za_q          <= '0;
      zd_out_q      <= '0;
      rsp_rdata_q   <= '0;
      zread_q       <= 1'b1;
      nas_q         <= 1'b1;
      nuds_q        <= 1'b1;
      nlds_q        <= 1'b1;
      zd_oe_q       <= 1'b0;
      zdoe_q        <= 1'b0;
      req_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      to_flag_q     <= 1'b0;
      ack_seen_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      be_q          <= be_d;
      za_q          <= za_d;
      zd_out_q      <= zd_out_d;
      rsp_rdata_q   <= rsp_rdata_d;
      zread_q       <= zread_d;
      nas_q         <= nas_d;
      nuds_q        <= nuds_d;
      nlds_q        <= nlds_d;
      zd_oe_q       <= zd_oe_d;
      zdoe_q        <= zdoe_d;
      req_ready_q   <= req_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_timeout_q <= rsp_timeout_d;
      to_flag_q     <= to_flag_d;
      ack_seen_q    <= ack_seen_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_timeout = rsp_timeout_q;
  assign znAS        = nas_q;
  assign znUDS       = nuds_q;
  assign znLDS       = nlds_q;
  assign zREAD       = zread_q;
  assign zA          = za_q;
  assign zD_out      = zd_out_q;
  assign zD_oe       = zd_oe_q;
  assign zDOE        = zdoe_q;

endmodule

// File: tb/tb_zorro_bus_master.sv
// Directed bench for zorro_bus_master: one DTACK-waiting instance and one fixed-strobe instance.
// Expected timings are hand-derived from the default cycle parameters.
module tb_zorro_bus_master;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        nw_req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [23:0] req_addr = '0;
  logic [1:0]  req_be = '0;
  logic [15:0] req_wdata = '0;
  logic [15:0] zD_in = '0;
  logic        znDTACK = 1'b1;
  logic        dtack_hi = 1'b1;

  logic        req_ready, rsp_valid, rsp_timeout, znAS, znUDS, znLDS, zREAD, zD_oe, zDOE;
  logic [15:0] rsp_rdata, zD_out;
  logic [23:0] zA;

  logic        nw_req_ready, nw_rsp_valid, nw_rsp_timeout, nw_znAS, nw_znUDS, nw_znLDS;
  logic        nw_zREAD, nw_zD_oe, nw_zDOE;
  logic [15:0] nw_rsp_rdata, nw_zD_out;
  logic [23:0] nw_zA;

  always #5 clk = ~clk;

  zorro_bus_master u_dut (
    .z_sample_clk (clk),       .reset_n     (reset_n),
    .req_valid    (req_valid), .req_ready   (req_ready),
    .req_write    (req_write), .req_addr    (req_addr),
    .req_be       (req_be),    .req_wdata   (req_wdata),
    .rsp_valid    (rsp_valid), .rsp_rdata   (rsp_rdata),
    .rsp_timeout  (rsp_timeout),
    .znAS         (znAS),      .znUDS       (znUDS),
    .znLDS        (znLDS),     .zREAD       (zREAD),
    .zA           (zA),        .zD_out      (zD_out),
    .zD_oe        (zD_oe),     .zD_in       (zD_in),
    .zDOE         (zDOE),      .znDTACK     (znDTACK)
  );

  zorro_bus_master #(.WAIT_DTACK(1'b0)) u_dut_nw (
    .z_sample_clk (clk),          .reset_n     (reset_n),
    .req_valid    (nw_req_valid), .req_ready   (nw_req_ready),
    .req_write    (req_write),    .req_addr    (req_addr),
    .req_be       (req_be),       .req_wdata   (req_wdata),
    .rsp_valid    (nw_rsp_valid), .rsp_rdata   (nw_rsp_rdata),
    .rsp_timeout  (nw_rsp_timeout),
    .znAS         (nw_znAS),      .znUDS       (nw_znUDS),
    .znLDS        (nw_znLDS),     .zREAD       (nw_zREAD),
    .zA           (nw_zA),        .zD_out      (nw_zD_out),
    .zD_oe        (nw_zD_oe),     .zD_in       (zD_in),
    .zDOE         (nw_zDOE),      .znDTACK     (dtack_hi)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bus monitor: edge numbers and phase lengths, sampled on the falling clock.
  int          cyc = 0;
  int          acc_count = 0, acc_cyc = 0;
  int          as_count = 0, as_fall_cyc = 0, as_high_cnt = 0, as_gap = 0;
  int          ds_count = 0, ds_fall_cyc = 0, ds_low_cnt = 0;
  int          doe_cnt = 0, oe_cnt = 0;
  int          rsp_count = 0, rsp_cyc = 0;
  logic [23:0] za_at_as = '0;
  logic        zread_at_as = 1'b1, oe_at_as = 1'b0, uds_seen = 1'b0, lds_seen = 1'b0;
  logic        last_to = 1'b0;
  logic [15:0] last_rd = '0;
  logic        prev_ready = 1'b1, prev_as = 1'b1, prev_ds = 1'b0, prev_doe = 1'b0;
  logic        ds_now;
  int          nw_ds_low_cnt = 0, nw_rsp_count = 0;
  logic        nw_last_to = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (prev_ready && !req_ready) begin acc_count++; acc_cyc = cyc; end
    prev_ready = req_ready;
    if (prev_as && !znAS) begin
      as_count++; as_fall_cyc = cyc; as_gap = as_high_cnt;
      za_at_as = zA; zread_at_as = zREAD; oe_at_as = zD_oe;
      uds_seen = 1'b0; lds_seen = 1'b0; oe_cnt = 0;
    end
    if (znAS) as_high_cnt++; else as_high_cnt = 0;
    prev_as = znAS;
    ds_now = !znUDS || !znLDS;
    if (ds_now && !prev_ds) begin ds_count++; ds_fall_cyc = cyc; ds_low_cnt = 0; end
    if (ds_now) ds_low_cnt++;
    prev_ds = ds_now;
    if (!znUDS) uds_seen = 1'b1;
    if (!znLDS) lds_seen = 1'b1;
    if (zDOE && !prev_doe) doe_cnt = 0;
    if (zDOE) doe_cnt++;
    prev_doe = zDOE;
    if (zD_oe) oe_cnt++;
    if (rsp_valid) begin rsp_count++; rsp_cyc = cyc; last_to = rsp_timeout; last_rd = rsp_rdata; end
    if (!nw_znUDS || !nw_znLDS) nw_ds_low_cnt++;
    if (nw_rsp_valid) begin nw_rsp_count++; nw_last_to = nw_rsp_timeout; end
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic issue(input logic wr, input logic [23:0] addr, input logic [1:0] be,
                       input logic [15:0] wd, input string tag);
    int base = acc_count;
    int n = 0;
    req_write = wr; req_addr = addr; req_be = be; req_wdata = wd;
    req_valid = 1'b1;
    while (acc_count == base && n < 100) begin tick(); n++; end
    req_valid = 1'b0;
    chk({tag, "_accept"}, 32'(acc_count != base), 32'd1);
  endtask

  task automatic wait_ds_low(input int base, input int len, input string tag);
    int n = 0;
    while (!(ds_count > base && ds_low_cnt >= len) && n < 200) begin tick(); n++; end
    chk({tag, "_ds_seen"}, 32'(ds_count > base), 32'd1);
  endtask

  task automatic wait_rsp(input int base, input string tag);
    int n = 0;
    while (rsp_count <= base && n < 1000) begin tick(); n++; end
    chk({tag, "_rsp_seen"}, 32'(rsp_count > base), 32'd1);
  endtask

  int b_rsp, b_ds, b_as, b_acc, n_w;

  initial begin
    tick(2);
    chk("rst_znAS", znAS, 1);   chk("rst_znUDS", znUDS, 1); chk("rst_znLDS", znLDS, 1);
    chk("rst_zREAD", zREAD, 1); chk("rst_zA", zA, 0);       chk("rst_zD_out", zD_out, 0);
    chk("rst_zD_oe", zD_oe, 0); chk("rst_zDOE", zDOE, 0);   chk("rst_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0); chk("rst_rdata", rsp_rdata, 0);
    reset_n = 1'b1;
    tick(3);

    // 1: read, DTACK 25 clocks after DS falls
    zD_in = 16'hBEEF; b_rsp = rsp_count; b_ds = ds_count;
    issue(1'b0, 24'h600010, 2'b11, 16'h0, "t1");
    wait_ds_low(b_ds, 25, "t1");
    znDTACK = 1'b0;
    wait_rsp(b_rsp, "t1");
    tick(2);
    znDTACK = 1'b1;
    chk("t1_as_delay", 32'(as_fall_cyc - acc_cyc), 32'd13);
    chk("t1_ds_delay", 32'(ds_fall_cyc - as_fall_cyc), 32'd14);
    chk("t1_ds_low", 32'(ds_low_cnt), 32'd27);
    chk("t1_rsp_delay", 32'(rsp_cyc - acc_cyc), 32'd61);
    chk("t1_zA", za_at_as, 24'h600010);
    chk("t1_zREAD", zread_at_as, 1);
    chk("t1_both_ds", {uds_seen, lds_seen}, 2'b11);
    chk("t1_rdata", last_rd, 16'hBEEF);
    chk("t1_timeout", last_to, 0);
    chk("t1_one_pulse", 32'(rsp_count - b_rsp), 32'd1);
    chk("t1_as_idle", znAS, 1);
    tick(3);

    // 2: byte write on the low lane, DTACK right after DS falls
    b_rsp = rsp_count; b_ds = ds_count;
    issue(1'b1, 24'hE80048, 2'b01, 16'h00A5, "t2");
    wait_ds_low(b_ds, 1, "t2");
    znDTACK = 1'b0;
    chk("t2_zD_out", zD_out, 16'h00A5);
    chk("t2_zD_oe_in_strobe", zD_oe, 1);
    wait_rsp(b_rsp, "t2");
    tick(2);
    znDTACK = 1'b1;
    chk("t2_zREAD", zread_at_as, 0);
    chk("t2_zA", za_at_as, 24'hE80048);
    chk("t2_oe_at_as", oe_at_as, 1);
    chk("t2_ds_lanes", {uds_seen, lds_seen}, 2'b01);
    chk("t2_ds_low", 32'(ds_low_cnt), 32'd20);
    chk("t2_oe_len", 32'(oe_cnt), 32'd42);
    chk("t2_doe_len", 32'(doe_cnt), 32'd8);
    chk("t2_oe_off", zD_oe, 0);
    chk("t2_timeout", last_to, 0);
    chk("t2_rdata_kept", last_rd, 16'hBEEF);
    tick(3);

    // 3: read, no DTACK at all
    zD_in = 16'h1234; b_rsp = rsp_count;
    issue(1'b0, 24'h600040, 2'b10, 16'h0, "t3");
    wait_rsp(b_rsp, "t3");
    tick(2);
    chk("t3_ds_low", 32'(ds_low_cnt), 32'd256);
    chk("t3_timeout", last_to, 1);
    chk("t3_rdata_kept", last_rd, 16'hBEEF);
    chk("t3_ds_lanes", {uds_seen, lds_seen}, 2'b10);
    tick(3);

    // 4: back-to-back reads with req_valid held, DTACK parked low
    zD_in = 16'hC0DE; znDTACK = 1'b0;
    b_rsp = rsp_count; b_as = as_count; b_acc = acc_count;
    req_write = 1'b0; req_addr = 24'h600000; req_be = 2'b11; req_valid = 1'b1;
    n_w = 0;
    while (as_count == b_as && n_w < 100) begin tick(); n_w++; end
    chk("t4_zA_first", za_at_as, 24'h600000);
    req_addr = 24'h600002;
    n_w = 0;
    while (acc_count < b_acc + 2 && n_w < 300) begin tick(); n_w++; end
    req_valid = 1'b0;
    chk("t4_second_accept", 32'(acc_count - b_acc), 32'd2);
    n_w = 0;
    while (rsp_count < b_rsp + 2 && n_w < 300) begin tick(); n_w++; end
    tick(2);
    znDTACK = 1'b1;
    chk("t4_rsp_pulses", 32'(rsp_count - b_rsp), 32'd2);
    chk("t4_zA_second", za_at_as, 24'h600002);
    chk("t4_as_gap", 32'(as_gap), 32'd14);
    chk("t4_ds_low", 32'(ds_low_cnt), 32'd20);
    chk("t4_rdata", last_rd, 16'hC0DE);
    tick(3);

    // 5: reset in the middle of a write strobe, then a normal read
    b_ds = ds_count;
    issue(1'b1, 24'h600020, 2'b11, 16'h1111, "t5");
    wait_ds_low(b_ds, 5, "t5");
    b_rsp = rsp_count;
    reset_n = 1'b0;
    #1;
    chk("t5_rst_znAS", znAS, 1);   chk("t5_rst_znUDS", znUDS, 1);
    chk("t5_rst_znLDS", znLDS, 1); chk("t5_rst_zD_oe", zD_oe, 0);
    chk("t5_rst_zA", zA, 0);       chk("t5_rst_ready", req_ready, 1);
    tick(3);
    reset_n = 1'b1;
    tick(3);
    chk("t5_no_rsp", 32'(rsp_count - b_rsp), 32'd0);
    zD_in = 16'h5A5A; b_rsp = rsp_count; b_ds = ds_count;
    issue(1'b0, 24'h600030, 2'b11, 16'h0, "t5b");
    wait_ds_low(b_ds, 1, "t5b");
    znDTACK = 1'b0;
    wait_rsp(b_rsp, "t5b");
    tick(2);
    znDTACK = 1'b1;
    chk("t5_rdata", last_rd, 16'h5A5A);
    chk("t5_timeout", last_to, 0);
    chk("t5_ds_low", 32'(ds_low_cnt), 32'd20);
    tick(3);

    // be=00: immediate response, no bus cycle
    b_rsp = rsp_count; b_as = as_count;
    issue(1'b0, 24'h600050, 2'b00, 16'h0, "t7");
    wait_rsp(b_rsp, "t7");
    tick(3);
    chk("t7_rsp_delay", 32'(rsp_cyc - acc_cyc), 32'd0);
    chk("t7_rdata", last_rd, 16'h0000);
    chk("t7_timeout", last_to, 0);
    chk("t7_no_as", 32'(as_count - b_as), 32'd0);
    chk("t7_ready_back", req_ready, 1);

    // 6: fixed strobe length, DTACK tied high
    nw_ds_low_cnt = 0;
    req_write = 1'b0; req_addr = 24'h600060; req_be = 2'b11;
    nw_req_valid = 1'b1;
    n_w = 0;
    while (nw_req_ready && n_w < 100) begin tick(); n_w++; end
    nw_req_valid = 1'b0;
    n_w = 0;
    while (nw_rsp_count == 0 && n_w < 500) begin tick(); n_w++; end
    tick(2);
    chk("t6_rsp_pulses", 32'(nw_rsp_count), 32'd1);
    chk("t6_ds_low", 32'(nw_ds_low_cnt), 32'd20);
    chk("t6_timeout", nw_last_to, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
